// File: rtl/display_scan_ctrl.sv
// Four-digit multiplexed display scanner. Frame-aligned double buffering keeps digits from tearing.
// Optional leading-zero blanking is enabled with the SCAN_LEADING_ZERO_BLANK_EN macro.
module display_scan_ctrl #(
    parameter int unsigned REFRESH_DIV = 27000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] data_in,
    input  logic        load,
    input  logic [3:0]  blank_mask,
    output logic [3:0]  bin,
    output logic [3:0]  an,
    output logic        pending,
    output logic        frame_done
);

    localparam logic [15:0] PrescMax = 16'(REFRESH_DIV - 1);

    logic [15:0] presc_q, presc_d;
    logic [1:0]  idx_q, idx_d;
    logic [15:0] shadow_q, shadow_d;
    logic [15:0] active_q, active_d;
    logic        pending_q, pending_d;
    logic [3:0]  an_q, an_d;
    logic [3:0]  bin_q, bin_d;
    logic        frame_done_q;

    logic        slot_end;
    logic        boundary;
    logic [3:0]  auto_blank;
    logic [3:0]  blank;
    logic [3:0]  digit_sel;

    assign slot_end = (presc_q == PrescMax);
    assign boundary = slot_end && (idx_q == 2'd3);

`ifdef SCAN_LEADING_ZERO_BLANK_EN
    // Digit k goes dark when it and every more-significant nibble are zero; digit 0 always shows.
    always_comb begin
        auto_blank    = 4'b0000;
        auto_blank[1] = (active_q[15:4] == 12'h000);
        auto_blank[2] = (active_q[15:8] == 8'h00);
        auto_blank[3] = (active_q[15:12] == 4'h0);
    end
`else
    assign auto_blank = 4'b0000;
`endif

    assign blank = blank_mask | auto_blank;

    always_comb begin
        presc_d = slot_end ? 16'd0 : presc_q + 16'd1;
        idx_d   = slot_end ? idx_q + 2'd1 : idx_q;
    end

    // A load on the boundary edge bypasses the shadow so it is never left pending.
    always_comb begin
        shadow_d  = shadow_q;
        active_d  = active_q;
        pending_d = pending_q;
        if (load && boundary) begin
            shadow_d  = data_in;
            active_d  = data_in;
            pending_d = 1'b0;
        end else if (load) begin
            shadow_d  = data_in;
            pending_d = 1'b1;
        end else if (boundary && pending_q) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end
    end

    always_comb begin
        digit_sel = 4'b0001 << idx_q;
        bin_d     = active_q[{idx_q, 2'b00} +: 4];
        if ((presc_q == 16'd0) || blank[idx_q]) begin
            an_d = 4'b1111;
        end else begin
            an_d = ~digit_sel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q      <= 16'd0;
            idx_q        <= 2'd0;
            shadow_q     <= 16'h0000;
            active_q     <= 16'h0000;
            pending_q    <= 1'b0;
            an_q         <= 4'b1111;
            bin_q        <= 4'b0000;
            frame_done_q <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            active_q     <= active_d;
            pending_q    <= pending_d;
            an_q         <= an_d;
            bin_q        <= bin_d;
            frame_done_q <= boundary;
        end
    end

    assign an         = an_q;
    assign bin        = bin_q;
    assign pending    = pending_q;
    assign frame_done = frame_done_q;

endmodule
